// File: rtl/dcache_req_ctrl_if.sv
// rtl/dcache_req_ctrl_if.sv - pipeline and L1 dcache signal bundle for dcache_req_ctrl
interface dcache_req_ctrl_if;
  logic        req_valid_i;
  logic        req_kill_i;
  logic        req_is_store_i;
  logic [39:0] req_addr_i;
  logic [63:0] req_data_i;
  logic [1:0]  req_size_i;
  logic        req_signed_i;
  logic        busy_o;
  logic        resp_valid_o;
  logic [63:0] resp_data_o;
  logic        xcpt_valid_o;
  logic [3:0]  xcpt_cause_o;
  logic [39:0] xcpt_addr_o;
  logic        dmem_req_valid_o;
  logic        dmem_req_ready_i;
  logic        dmem_req_cmd_o;
  logic [39:0] dmem_req_addr_o;
  logic [1:0]  dmem_req_size_o;
  logic [63:0] dmem_req_data_o;
  logic        dmem_req_kill_o;
  logic        dmem_resp_valid_i;
  logic        dmem_resp_nack_i;
  logic [63:0] dmem_resp_data_i;

  // slave: the request controller; master: pipeline plus dcache side
  modport slave (
    input  req_valid_i, req_kill_i, req_is_store_i, req_addr_i, req_data_i,
           req_size_i, req_signed_i, dmem_req_ready_i, dmem_resp_valid_i,
           dmem_resp_nack_i, dmem_resp_data_i,
    output busy_o, resp_valid_o, resp_data_o, xcpt_valid_o, xcpt_cause_o,
           xcpt_addr_o, dmem_req_valid_o, dmem_req_cmd_o, dmem_req_addr_o,
           dmem_req_size_o, dmem_req_data_o, dmem_req_kill_o
  );

  modport master (
    output req_valid_i, req_kill_i, req_is_store_i, req_addr_i, req_data_i,
           req_size_i, req_signed_i, dmem_req_ready_i, dmem_resp_valid_i,
           dmem_resp_nack_i, dmem_resp_data_i,
    input  busy_o, resp_valid_o, resp_data_o, xcpt_valid_o, xcpt_cause_o,
           xcpt_addr_o, dmem_req_valid_o, dmem_req_cmd_o, dmem_req_addr_o,
           dmem_req_size_o, dmem_req_data_o, dmem_req_kill_o
  );
endinterface

// File: rtl/dcache_req_ctrl.sv
// rtl/dcache_req_ctrl.sv - single-op load/store request controller in front of the L1 dcache
module dcache_req_ctrl (
  input logic             clk_i,
  input logic             rstn_i,
  dcache_req_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        cmd_q, signed_q, xcpt_q;
  logic [39:0] addr_q;
  logic [1:0]  size_q;
  logic [63:0] data_q, resp_data_q, load_ext;
  logic [2:0]  retry_q;
  logic [3:0]  cause_q;
  logic        accept, resp_ok, retry_inc, nack_xcpt, busy, req_kill, misaligned;
  logic [63:0] shifted;

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size_i)
      2'b01:   misaligned = bus.req_addr_i[0];
      2'b10:   misaligned = |bus.req_addr_i[1:0];
      2'b11:   misaligned = |bus.req_addr_i[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    resp_ok   = 1'b0;
    retry_inc = 1'b0;
    nack_xcpt = 1'b0;
    busy      = 1'b0;
    req_kill  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.req_valid_i && !bus.req_kill_i) begin
        accept  = 1'b1;
        busy    = 1'b1;
        state_d = misaligned ? S_DONE : S_REQ;
      end
      S_REQ: begin
        busy = 1'b1;
        // a handshake wins over a same-cycle kill; the kill is then ignored
        if (bus.dmem_req_ready_i)   state_d = S_WAIT;
        else if (bus.req_kill_i)    state_d = S_IDLE;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (bus.req_kill_i) begin
          req_kill = 1'b1;
          state_d  = bus.dmem_resp_valid_i ? S_IDLE : S_DRAIN;
        end else if (bus.dmem_resp_valid_i) begin
          if (!bus.dmem_resp_nack_i) begin
            resp_ok = 1'b1;
            state_d = S_DONE;
          end else if (retry_q == 3'd7) begin
            nack_xcpt = 1'b1;
            state_d   = S_DONE;
          end else begin
            retry_inc = 1'b1;
            state_d   = S_REQ;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (bus.dmem_resp_valid_i) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign shifted = bus.dmem_resp_data_i >> {addr_q[2:0], 3'b000};

  always_comb begin
    load_ext = shifted;
    case (size_q)
      2'b00:   load_ext = {{56{signed_q & shifted[7]}},  shifted[7:0]};
      2'b01:   load_ext = {{48{signed_q & shifted[15]}}, shifted[15:0]};
      2'b10:   load_ext = {{32{signed_q & shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      cmd_q       <= 1'b0;
      signed_q    <= 1'b0;
      xcpt_q      <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
      retry_q     <= '0;
      cause_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_q       <= bus.req_is_store_i;
        signed_q    <= bus.req_signed_i;
        addr_q      <= bus.req_addr_i;
        size_q      <= bus.req_size_i;
        data_q      <= bus.req_data_i;
        retry_q     <= '0;
        resp_data_q <= '0;
        xcpt_q      <= misaligned;
        cause_q     <= bus.req_is_store_i ? 4'd6 : 4'd4;
      end
      if (resp_ok)   resp_data_q <= cmd_q ? 64'd0 : load_ext;
      if (retry_inc) retry_q <= retry_q + 3'd1;
      if (nack_xcpt) begin
        xcpt_q  <= 1'b1;
        cause_q <= cmd_q ? 4'd7 : 4'd5;
      end
    end
  end

  always_comb begin
    bus.dmem_req_data_o = data_q;
    case (size_q)
      2'b00:   bus.dmem_req_data_o = {8{data_q[7:0]}};
      2'b01:   bus.dmem_req_data_o = {4{data_q[15:0]}};
      2'b10:   bus.dmem_req_data_o = {2{data_q[31:0]}};
      default: bus.dmem_req_data_o = data_q;
    endcase
  end

  // busy and kill are combinational from inputs, so force them low under reset
  assign bus.busy_o           = busy & rstn_i;
  assign bus.dmem_req_kill_o  = req_kill & rstn_i;
  assign bus.dmem_req_valid_o = (state_q == S_REQ);
  assign bus.dmem_req_cmd_o   = cmd_q;
  assign bus.dmem_req_addr_o  = addr_q;
  assign bus.dmem_req_size_o  = size_q;
  assign bus.resp_valid_o     = (state_q == S_DONE);
  assign bus.resp_data_o      = resp_data_q;
  assign bus.xcpt_valid_o     = (state_q == S_DONE) & xcpt_q;
  assign bus.xcpt_cause_o     = bus.xcpt_valid_o ? cause_q : 4'd0;
  assign bus.xcpt_addr_o      = bus.xcpt_valid_o ? addr_q : 40'd0;
endmodule
